aes_key_sched_ctrl: RTL and testbench

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

---
 rtl/aes_key_sched_ctrl.sv | 153 +++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// aes_key_sched_ctrl
//
// Sequencing controller for an AES key-expansion datapath. On an accepted
// start it presents round key 0, then for each following round runs a
// six-step expansion (ADDRK, cnt 0..5) and presents the new round key (HOLD)
// until the consumer accepts it. After round NR is accepted a one-cycle done
// pulse is issued and the controller returns to IDLE.
//
// Parameters:
//   NR            number of expansion rounds, 1..10 (default 10)
//
// Ports:
//   clk           clock, all state updates on its rising edge
//   rst_n         synchronous active-low reset
//   start         request a full key schedule (sampled only in IDLE)
//   inv_en_i      schedule direction, captured on an accepted start
//   rk_ready      consumer accepts the presented round key
//   abort         (AES_KSCHED_ABORT_EN only) drop the schedule, back to IDLE
//   current_state state code to the datapath (0 IDLE, 1 ADDRK, 2 HOLD, 3 DONE)
//   round         round index 0..NR
//   cnt           intra-round step counter 0..5
//   inv_en        registered direction, stable while busy
//   rk_valid      round key for 'round' is stable on the datapath output
//   busy          state is not IDLE
//   done          one-cycle pulse after round NR is accepted
//
// Optional feature macro: AES_KSCHED_ABORT_EN (adds the abort input).
//
// Handshake: rk_valid/rk_ready follow valid/ready rules. rk_valid is high
// only in HOLD and, once high, stays high with round unchanged until the
// cycle in which rk_ready is also high; that cycle is the transfer. rk_ready
// has no effect in any other state.
// ---------------------------------------------------------------------------
module aes_key_sched_ctrl #(
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       inv_en_i,
    input  logic       rk_ready,
`ifdef AES_KSCHED_ABORT_EN
    input  logic       abort,
`endif
    output logic [2:0] current_state,
    output logic [3:0] round,
    output logic [3:0] cnt,
    output logic       inv_en,
    output logic       rk_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDRK = 3'd1,
        HOLD  = 3'd2,
        DONE  = 3'd3
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR);
    localparam logic [3:0] LAST_STEP  = 4'd5;

    state_t     state, state_n;
    logic [3:0] round_n;
    logic [3:0] cnt_n;
    logic       inv_en_n;
    logic       abort_w;

`ifdef AES_KSCHED_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            round  <= 4'd0;
            cnt    <= 4'd0;
            inv_en <= 1'b0;
        end else begin
            state  <= state_n;
            round  <= round_n;
            cnt    <= cnt_n;
            inv_en <= inv_en_n;
        end
    end

    always_comb begin
        state_n  = state;
        round_n  = round;
        cnt_n    = cnt;
        inv_en_n = inv_en;
        rk_valid = 1'b0;
        done     = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n  = HOLD;
                    round_n  = 4'd0;
                    cnt_n    = 4'd0;
                    inv_en_n = inv_en_i;
                end
            end
            HOLD: begin
                rk_valid = 1'b1;
                if (rk_ready) begin
                    if (round == LAST_ROUND) begin
                        state_n = DONE;
                    end else begin
                        state_n = ADDRK;
                        round_n = round + 4'd1;
                        cnt_n   = 4'd0;
                    end
                end
            end
            ADDRK: begin
                // The datapath writes the new round key back on step 5.
                if (cnt == LAST_STEP) begin
                    state_n = HOLD;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
                round_n = 4'd0;
            end
            default: begin
                state_n = IDLE;
                round_n = 4'd0;
                cnt_n   = 4'd0;
            end
        endcase

        // Abort wins over any handshake; the done pulse of a DONE cycle has
        // already been presented, so no extra pulse is created here.
        if (abort_w && (state != IDLE)) begin
            state_n = IDLE;
            round_n = 4'd0;
            cnt_n   = 4'd0;
        end
    end

    assign current_state = state;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_key_sched_ctrl
//
// Two instances: dut_a with NR=10 and dut_b with NR=1, driven by the same
// inputs. Each has a behavioural model (per-cycle phase/round/step tracking)
// and an expected-round queue filled with 0..NR on every accepted start and
// drained on every observed key transfer.
// ---------------------------------------------------------------------------
module tb_aes_key_sched_ctrl;

    localparam int NR_A = 10;
    localparam int NR_B = 1;

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n    = 1'b0;
    logic start    = 1'b0;
    logic inv_en_i = 1'b0;
    logic rk_ready = 1'b0;
    logic abort    = 1'b0;

    logic [2:0] cs_a, cs_b;
    logic [3:0] round_a, round_b, cnt_a, cnt_b;
    logic       inv_a, inv_b, valid_a, valid_b, busy_a, busy_b, done_a, done_b;

    aes_key_sched_ctrl #(.NR(NR_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .inv_en_i(inv_en_i),
        .rk_ready(rk_ready),
`ifdef AES_KSCHED_ABORT_EN
        .abort(abort),
`endif
        .current_state(cs_a), .round(round_a), .cnt(cnt_a), .inv_en(inv_a),
        .rk_valid(valid_a), .busy(busy_a), .done(done_a)
    );

    aes_key_sched_ctrl #(.NR(NR_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .inv_en_i(inv_en_i),
        .rk_ready(rk_ready),
`ifdef AES_KSCHED_ABORT_EN
        .abort(abort),
`endif
        .current_state(cs_b), .round(round_b), .cnt(cnt_b), .inv_en(inv_b),
        .rk_valid(valid_b), .busy(busy_b), .done(done_b)
    );

    // behavioural reference model
    // phase: 0 idle, 1 expanding (step = 0..5), 2 key presented, 3 finishing
    typedef struct {
        int phase;
        int rnd;
        int step;
        int inv;
    } model_t;

    model_t ma, mb;
    logic [3:0] exp_qa[$];
    logic [3:0] exp_qb[$];

    int tests = 0;
    int fails = 0;

    function automatic model_t model_next(model_t m, int nr);
        model_t n = m;
        if (!rst_n) begin
            n.phase = 0; n.rnd = 0; n.step = 0; n.inv = 0;
            return n;
        end
        if (abort === 1'b1 && m.phase != 0) begin
            n.phase = 0; n.rnd = 0; n.step = 0;
            return n;
        end
        case (m.phase)
            0: if (start) begin
                n.phase = 2; n.rnd = 0; n.step = 0; n.inv = int'(inv_en_i);
            end
            2: if (rk_ready) begin
                if (m.rnd == nr) n.phase = 3;
                else begin n.phase = 1; n.rnd = m.rnd + 1; n.step = 0; end
            end
            1: if (m.step == 5) begin n.phase = 2; n.step = 0; end
               else n.step = m.step + 1;
            default: begin n.phase = 0; n.rnd = 0; end
        endcase
        return n;
    endfunction

    // state code expected on current_state for each model phase
    function automatic int phase_code(int phase);
        case (phase)
            1: return 1;
            2: return 2;
            3: return 3;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        tests++;
        assert (obs === 32'(exp)) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input string p, input model_t m,
                           input logic [2:0] cs, input logic [3:0] r, input logic [3:0] c,
                           input logic iv, input logic v, input logic b, input logic d);
        chk({p, "_state"}, 32'(cs), phase_code(m.phase));
        chk({p, "_round"}, 32'(r), m.rnd);
        chk({p, "_cnt"}, 32'(c), m.step);
        chk({p, "_inv_en"}, 32'(iv), m.inv);
        chk({p, "_rk_valid"}, 32'(v), int'(m.phase == 2));
        chk({p, "_busy"}, 32'(b), int'(m.phase != 0));
        chk({p, "_done"}, 32'(d), int'(m.phase == 3));
    endtask

    // scoreboard update for one instance, evaluated just before the edge
    task automatic sb_a();
        if (!rst_n || (abort && ma.phase != 0)) begin
            exp_qa.delete();
        end else if (ma.phase == 0 && start) begin
            for (int i = 0; i <= NR_A; i++) exp_qa.push_back(4'(i));
        end else if (valid_a && rk_ready) begin
            chk("sb_a_nonempty", 32'(exp_qa.size() != 0), 1);
            if (exp_qa.size() != 0) chk("sb_a_round", 32'(round_a), int'(exp_qa.pop_front()));
        end
        if (done_a) chk("sb_a_drained", 32'(exp_qa.size()), 0);
    endtask

    task automatic sb_b();
        if (!rst_n || (abort && mb.phase != 0)) begin
            exp_qb.delete();
        end else if (mb.phase == 0 && start) begin
            for (int i = 0; i <= NR_B; i++) exp_qb.push_back(4'(i));
        end else if (valid_b && rk_ready) begin
            chk("sb_b_nonempty", 32'(exp_qb.size() != 0), 1);
            if (exp_qb.size() != 0) chk("sb_b_round", 32'(round_b), int'(exp_qb.pop_front()));
        end
        if (done_b) chk("sb_b_drained", 32'(exp_qb.size()), 0);
    endtask

    // driver: one clock cycle, inputs already set; outputs checked at negedge
    task automatic cycle();
        sb_a();
        sb_b();
        @(posedge clk);
        ma = model_next(ma, NR_A);
        mb = model_next(mb, NR_B);
        @(negedge clk);
        chk_dut("a", ma, cs_a, round_a, cnt_a, inv_a, valid_a, busy_a, done_a);
        chk_dut("b", mb, cs_b, round_b, cnt_b, inv_b, valid_b, busy_b, done_b);
    endtask

    // run cycles until dut_a shows the given state/round/cnt (cnt<0: any)
    task automatic wait_a(input int st, input int r, input int c, input string tag);
        int k = 0;
        logic ok;
        ok = 1'b0;
        while (k < 300) begin
            if (int'(cs_a) == st && int'(round_a) == r && (c < 0 || int'(cnt_a) == c)) begin
                ok = 1'b1;
                break;
            end
            cycle();
            k++;
        end
        chk(tag, 32'(ok), 1);
    endtask

    task automatic run_to_idle_a(input string tag);
        int k = 0;
        logic ok;
        ok = 1'b0;
        while (k < 300) begin
            if (!busy_a) begin ok = 1'b1; break; end
            cycle();
            k++;
        end
        chk(tag, 32'(ok), 1);
    endtask

    initial begin
        int n, nb;
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};

        // reset
        @(negedge clk);
        cycle();
        cycle();
        chk("reset_state", 32'(cs_a), 0);
        chk("reset_busy", 32'(busy_a), 0);
        rst_n = 1'b1;
        cycle();

        // full schedule with rk_ready held high: done 72 cycles after start
        inv_en_i = 1'b0;
        rk_ready = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        n = 1;
        nb = 0;
        chk("first_key_round", 32'(round_a), 0);
        while (!done_a && n < 200) begin
            cycle();
            n++;
            if (done_b && nb == 0) nb = n;
        end
        chk("latency_nr10", 32'(n), 1 + 7 * NR_A + 1);
        chk("latency_nr1", 32'(nb), 1 + 7 * NR_B + 1);
        cycle();
        chk("busy_after_done", 32'(busy_a), 0);

        // stall at round 3, with start pulses while busy
        inv_en_i = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_a(2, 3, 0, "reach_hold_r3");
        rk_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            start    = (i == 5 || i == 15);
            inv_en_i = (i == 5 || i == 15);
            cycle();
        end
        start = 1'b0;
        chk("stall_state", 32'(cs_a), 2);
        chk("stall_round", 32'(round_a), 3);
        chk("stall_inv", 32'(inv_a), 0);
        rk_ready = 1'b1;
        cycle();
        chk("addrk_after_ready", 32'(cs_a), 1);
        chk("addrk_round", 32'(round_a), 4);
        run_to_idle_a("stall_run_done");

        // reset in the middle of an expansion
        inv_en_i = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_a(1, 6, 3, "reach_addrk_r6_c3");
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("midrst_state", 32'(cs_a), 0);
        chk("midrst_round", 32'(round_a), 0);
        chk("midrst_inv", 32'(inv_a), 0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("restart_valid", 32'(valid_a), 1);
        chk("restart_round", 32'(round_a), 0);
        run_to_idle_a("restart_run_done");

        // NR=1 instance with inverse direction
        inv_en_i = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        inv_en_i = 1'b0;
        chk("b_inv_captured", 32'(inv_b), 1);
        for (int i = 0; i < 12; i++) cycle();
        chk("b_back_idle", 32'(busy_b), 0);
        run_to_idle_a("inv_run_done");

`ifdef AES_KSCHED_ABORT_EN
        // abort while a key is presented and accepted in the same cycle
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_a(2, 4, 0, "reach_hold_r4");
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("abort_state", 32'(cs_a), 0);
        chk("abort_valid", 32'(valid_a), 0);
        chk("abort_no_done", 32'(done_a), 0);
        for (int i = 0; i < 4; i++) cycle();
`endif

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            start    = ($urandom_range(0, 7) == 0);
            inv_en_i = 1'($urandom_range(0, 1));
            rk_ready = ($urandom_range(0, 3) != 0);
            rst_n    = ($urandom_range(0, 99) != 0);
`ifdef AES_KSCHED_ABORT_EN
            abort    = ($urandom_range(0, 49) == 0);
`endif
            cycle();
        end
        rst_n = 1'b1;
        abort = 1'b0;
        start = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
